// File: rtl/hpc3_rand_gen.sv
// rtl/hpc3_rand_gen.sv - xorshift32 mask bundle generator for an HPC3 multiplier; optional HPC3_RAND_CNT_EN adds rnd_cnt
module hpc3_rand_gen #(
    parameter int unsigned WARMUP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_valid,
    input  logic [31:0] seed,
    input  logic        rnd_ready,
    output logic        rnd_valid,
    output logic [79:0] r_bus,
    output logic [79:0] p_bus
`ifdef HPC3_RAND_CNT_EN
    ,
    output logic [15:0] rnd_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [7:0]  WARM_LOAD = 8'(WARMUP_CYCLES);
    localparam logic        WARM_EN   = (WARMUP_CYCLES != 0);
    localparam logic [2:0]  WORDS     = 3'd5;
    localparam logic [31:0] X_RESET   = 32'h0000_0001;

    state_t         state_q, state_d;
    logic [31:0]    x_q, x_d;
    logic [7:0]     warm_cnt_q, warm_cnt_d;
    logic [2:0]     word_cnt_q, word_cnt_d;
    logic [159:0]   staging_q, staging_d;
    logic           rnd_valid_q, rnd_valid_d;
    logic [79:0]    r_bus_q, r_bus_d;
    logic [79:0]    p_bus_q, p_bus_d;

    logic [31:0]    xs_s1, xs_s2, prng_word;
    logic [31:0]    seed_x;
    logic           load;
    logic           step;
    logic           wr_word;
    logic           xfer;
    logic           hshk;

    // one xorshift32 step from the current state; an all-zero seed would lock up, so it maps to 1
    always_comb begin
        xs_s1     = x_q ^ (x_q << 13);
        xs_s2     = xs_s1 ^ (xs_s1 >> 17);
        prng_word = xs_s2 ^ (xs_s2 << 5);
        seed_x    = (seed == 32'd0) ? X_RESET : seed;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a seed load restarts from any state and wins over everything else
    always_comb begin
        state_d = state_q;
        if (seed_valid) begin
            state_d = WARM_EN ? WARMUP : RUN;
        end else if (state_q == WARMUP && warm_cnt_q == 8'd1) begin
            state_d = RUN;
        end
    end

    // FSM outputs: datapath strobes; the PRNG only advances while words are still needed
    always_comb begin
        load    = seed_valid;
        step    = 1'b0;
        wr_word = 1'b0;
        xfer    = 1'b0;
        hshk    = rnd_valid_q && rnd_ready;
        if (!seed_valid) begin
            case (state_q)
                WARMUP: step = 1'b1;
                RUN: begin
                    if (word_cnt_q != WORDS) begin
                        step    = 1'b1;
                        wr_word = 1'b1;
                    end else if (!rnd_valid_q || rnd_ready) begin
                        xfer = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // datapath next state: staging fill, bundle transfer and valid/ready bookkeeping
    always_comb begin
        x_d         = x_q;
        warm_cnt_d  = warm_cnt_q;
        word_cnt_d  = word_cnt_q;
        staging_d   = staging_q;
        rnd_valid_d = rnd_valid_q;
        r_bus_d     = r_bus_q;
        p_bus_d     = p_bus_q;
        if (load) begin
            x_d         = seed_x;
            warm_cnt_d  = WARM_LOAD;
            word_cnt_d  = 3'd0;
            staging_d   = '0;
            rnd_valid_d = 1'b0;
        end else begin
            if (step) begin
                x_d = prng_word;
            end
            if (state_q == WARMUP) begin
                warm_cnt_d = warm_cnt_q - 8'd1;
            end
            if (wr_word) begin
                word_cnt_d = word_cnt_q + 3'd1;
                case (word_cnt_q)
                    3'd0:    staging_d[31:0]    = prng_word;
                    3'd1:    staging_d[63:32]   = prng_word;
                    3'd2:    staging_d[95:64]   = prng_word;
                    3'd3:    staging_d[127:96]  = prng_word;
                    default: staging_d[159:128] = prng_word;
                endcase
            end
            if (xfer) begin
                r_bus_d     = staging_q[79:0];
                p_bus_d     = staging_q[159:80];
                word_cnt_d  = 3'd0;
                rnd_valid_d = 1'b1;
            end else if (hshk) begin
                rnd_valid_d = 1'b0;
            end
        end
    end

    // datapath registers; reset discards any partially built bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= X_RESET;
            warm_cnt_q  <= 8'd0;
            word_cnt_q  <= 3'd0;
            staging_q   <= '0;
            rnd_valid_q <= 1'b0;
            r_bus_q     <= '0;
            p_bus_q     <= '0;
        end else begin
            x_q         <= x_d;
            warm_cnt_q  <= warm_cnt_d;
            word_cnt_q  <= word_cnt_d;
            staging_q   <= staging_d;
            rnd_valid_q <= rnd_valid_d;
            r_bus_q     <= r_bus_d;
            p_bus_q     <= p_bus_d;
        end
    end

    assign rnd_valid = rnd_valid_q;
    assign r_bus     = r_bus_q;
    assign p_bus     = p_bus_q;

`ifdef HPC3_RAND_CNT_EN
    logic [15:0] rnd_cnt_q, rnd_cnt_d;

    // handshake counter, restarted by every seed load, wraps naturally
    always_comb begin
        rnd_cnt_d = rnd_cnt_q;
        if (load) begin
            rnd_cnt_d = 16'd0;
        end else if (hshk) begin
            rnd_cnt_d = rnd_cnt_q + 16'd1;
        end
    end

    // handshake counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_cnt_q <= 16'd0;
        end else begin
            rnd_cnt_q <= rnd_cnt_d;
        end
    end

    assign rnd_cnt = rnd_cnt_q;
`endif

endmodule
